// File: rtl/uriscv_defs.sv
// -----------------------------------------------------------------------------
// uriscv_defs
// Shared definitions for the uRISC-V RV32M multiply/divide unit.
//   mul_op_e / div_op_e  : compact encodings of the one-hot M-extension decode
//   DIV_ZERO_QUOTIENT    : quotient produced by any divide by zero
//   DIV_MASK_INIT        : first quotient bit resolved by the divider
//   *_ok functions       : parameter legality checks used at elaboration
// -----------------------------------------------------------------------------
package uriscv_defs;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_MASK_INIT     = 32'h8000_0000;

  function automatic bit mul_latency_ok(input int lat);
    return (lat >= 1) && (lat <= 3);
  endfunction

  function automatic bit div_bits_ok(input int bits);
    return (bits == 1) || (bits == 2) || (bits == 4);
  endfunction

  function automatic bit early_out_ok(input int en);
    return (en == 0) || (en == 1);
  endfunction

endpackage

// File: rtl/uriscv_muldiv_pipe_if.sv
// -----------------------------------------------------------------------------
// uriscv_muldiv_pipe_if
// Execute-stage handshake between the core (master) and the mul/div unit
// (slave).
//   valid_i, inst_*_i, operand_ra_i, operand_rb_i, flush_i : core -> unit
//   stall_o, busy_o, ready_o, result_o                      : unit -> core
// -----------------------------------------------------------------------------
interface uriscv_muldiv_pipe_if;

  logic        valid_i;
  logic        inst_mul_i;
  logic        inst_mulh_i;
  logic        inst_mulhsu_i;
  logic        inst_mulhu_i;
  logic        inst_div_i;
  logic        inst_divu_i;
  logic        inst_rem_i;
  logic        inst_remu_i;
  logic [31:0] operand_ra_i;
  logic [31:0] operand_rb_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;

  modport master (
    output valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
           inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
           operand_ra_i, operand_rb_i, flush_i,
    input  stall_o, busy_o, ready_o, result_o
  );

  modport slave (
    input  valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
           inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
           operand_ra_i, operand_rb_i, flush_i,
    output stall_o, busy_o, ready_o, result_o
  );

endinterface

// File: rtl/uriscv_div_iter.sv
// -----------------------------------------------------------------------------
// uriscv_div_iter
// Iterative restoring divider for DIV/DIVU/REM/REMU. Operands are made
// non-negative at start, the divisor is pre-shifted left by 31 and a one-hot
// mask walks from bit 31 down to zero, DIV_BITS_PER_CYCLE bits per cycle.
// Signed results are restored by a latched invert flag.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : abandon the operation in progress
//   start_i, op_i : begin a new operation of the given kind
//   ra_i, rb_i    : dividend / divisor
//   busy_o        : operation in progress (including its completion cycle)
//   complete_o    : this cycle is the completion cycle; result_o is valid
//   result_o      : quotient or remainder, sign corrected
// -----------------------------------------------------------------------------
module uriscv_div_iter
  import uriscv_defs::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int DIV_EARLY_OUT      = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        start_i,
  input  div_op_e     op_i,
  input  logic [31:0] ra_i,
  input  logic [31:0] rb_i,
  output logic        busy_o,
  output logic        complete_o,
  output logic [31:0] result_o
);

  if (!div_bits_ok(DIV_BITS_PER_CYCLE)) begin : g_bad_div_bits
    $error("uriscv_div_iter: DIV_BITS_PER_CYCLE must be 1, 2 or 4");
  end
  if (!early_out_ok(DIV_EARLY_OUT)) begin : g_bad_early_out
    $error("uriscv_div_iter: DIV_EARLY_OUT must be 0 or 1");
  end

  localparam bit EARLY_OUT_EN = (DIV_EARLY_OUT != 0);

  logic        busy_r;
  logic        quot_mode_r;
  logic        invert_r;
  logic [31:0] dividend_r;
  logic [62:0] divisor_r;
  logic [31:0] quotient_r;
  logic [31:0] mask_r;

  logic        signed_s;
  logic        quot_s;
  logic        invert_s;
  logic        zero_early_s;
  logic [31:0] ra_abs_s;
  logic [31:0] rb_abs_s;
  logic [31:0] dvd_s;
  logic [62:0] dvs_s;
  logic [31:0] quo_s;
  logic [31:0] msk_s;

  // Operand preparation for a new operation.
  always_comb begin
    signed_s = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
    quot_s   = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_DIVU);
    if (signed_s && ra_i[31]) begin
      ra_abs_s = 32'd0 - ra_i;
    end else begin
      ra_abs_s = ra_i;
    end
    if (signed_s && rb_i[31]) begin
      rb_abs_s = 32'd0 - rb_i;
    end else begin
      rb_abs_s = rb_i;
    end
    // A zero divisor never inverts the quotient, so x/0 yields all ones.
    invert_s = ((op_i == DIV_OP_DIV) && (ra_i[31] != rb_i[31]) && (rb_i != 32'd0)) ||
               ((op_i == DIV_OP_REM) && ra_i[31]);
    zero_early_s = EARLY_OUT_EN && (rb_i == 32'd0);
  end

  // Chained compare/subtract/shift steps resolved in one busy cycle.
  always_comb begin
    dvd_s = dividend_r;
    dvs_s = divisor_r;
    quo_s = quotient_r;
    msk_s = mask_r;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      if (dvs_s <= {31'd0, dvd_s}) begin
        dvd_s = dvd_s - dvs_s[31:0];
        quo_s = quo_s | msk_s;
      end else begin
        dvd_s = dvd_s;
        quo_s = quo_s;
      end
      dvs_s = dvs_s >> 1;
      msk_s = msk_s >> 1;
    end
  end

  // Divider state: load on start, iterate while busy, drop on completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r      <= 1'b0;
      quot_mode_r <= 1'b0;
      invert_r    <= 1'b0;
      dividend_r  <= 32'd0;
      divisor_r   <= 63'd0;
      quotient_r  <= 32'd0;
      mask_r      <= 32'd0;
    end else if (flush_i) begin
      busy_r <= 1'b0;
      mask_r <= 32'd0;
    end else if (start_i) begin
      busy_r      <= 1'b1;
      quot_mode_r <= quot_s;
      invert_r    <= invert_s;
      dividend_r  <= ra_abs_s;
      // Early out: a zero divisor would set every quotient bit and leave the
      // dividend untouched, so jump straight to that final state.
      if (zero_early_s) begin
        divisor_r  <= 63'd0;
        quotient_r <= DIV_ZERO_QUOTIENT;
        mask_r     <= 32'd0;
      end else begin
        divisor_r  <= {rb_abs_s, 31'd0};
        quotient_r <= 32'd0;
        mask_r     <= DIV_MASK_INIT;
      end
    end else if (busy_r) begin
      if (mask_r == 32'd0) begin
        busy_r <= 1'b0;
      end else begin
        dividend_r <= dvd_s;
        divisor_r  <= dvs_s;
        quotient_r <= quo_s;
        mask_r     <= msk_s;
      end
    end
  end

  // Sign-corrected result selection.
  always_comb begin
    if (quot_mode_r) begin
      result_o = invert_r ? (32'd0 - quotient_r) : quotient_r;
    end else begin
      result_o = invert_r ? (32'd0 - dividend_r) : dividend_r;
    end
  end

  assign busy_o     = busy_r;
  assign complete_o = busy_r && (mask_r == 32'd0);

endmodule

// File: rtl/uriscv_muldiv_pipe.sv
// -----------------------------------------------------------------------------
// uriscv_muldiv_pipe
// RV32M multiply/divide unit for the uRISC-V execute stage. Multiplies are
// computed in the accept cycle and carried through MUL_LATENCY valid-tagged
// stages, one op per cycle. Divides use the iterative uriscv_div_iter core.
// Both paths share one registered result/ready pair; the stall rule keeps
// their completions from ever colliding.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : valid_i, inst_*_i, operand_ra_i, operand_rb_i, flush_i in;
//                  stall_o (combinational), busy_o, ready_o, result_o out
// -----------------------------------------------------------------------------
module uriscv_muldiv_pipe
  import uriscv_defs::*;
#(
  parameter int MUL_LATENCY        = 1,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int DIV_EARLY_OUT      = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  uriscv_muldiv_pipe_if.slave  bus
);

  if (!mul_latency_ok(MUL_LATENCY)) begin : g_bad_mul_latency
    $error("uriscv_muldiv_pipe: MUL_LATENCY must be 1..3");
  end

  logic        mul_op_s;
  logic        div_op_s;
  logic        stall_s;
  logic        accept_s;
  logic        mul_accept_s;
  logic        div_start_s;
  mul_op_e     mul_sel_s;
  div_op_e     div_sel_s;
  logic [32:0] mul_a_s;
  logic [32:0] mul_b_s;
  logic [63:0] mul_a_ext_s;
  logic [63:0] mul_b_ext_s;
  logic [63:0] mul_prod_s;
  logic [31:0] mul_res_s;
  logic        div_busy_s;
  logic        div_complete_s;
  logic [31:0] div_result_s;

  logic [MUL_LATENCY-1:0] mul_valid_r;
  logic [31:0]            mul_data_r [MUL_LATENCY];
  logic                   ready_r;
  logic [31:0]            result_r;

  assign mul_op_s = bus.inst_mul_i | bus.inst_mulh_i | bus.inst_mulhsu_i | bus.inst_mulhu_i;
  assign div_op_s = bus.inst_div_i | bus.inst_divu_i | bus.inst_rem_i | bus.inst_remu_i;

  // A divide may not start while multiplies are in flight, and nothing may
  // start while the divider is busy, so the two paths never finish together.
  assign stall_s = bus.valid_i &
                   ((div_busy_s & (mul_op_s | div_op_s)) | ((|mul_valid_r) & div_op_s));
  assign accept_s     = bus.valid_i & (mul_op_s | div_op_s) & ~stall_s & ~bus.flush_i;
  assign mul_accept_s = accept_s & mul_op_s;
  assign div_start_s  = accept_s & div_op_s & ~mul_op_s;

  // One-hot decode to compact op encodings.
  always_comb begin
    if (bus.inst_mulh_i) begin
      mul_sel_s = MUL_OP_MULH;
    end else if (bus.inst_mulhsu_i) begin
      mul_sel_s = MUL_OP_MULHSU;
    end else if (bus.inst_mulhu_i) begin
      mul_sel_s = MUL_OP_MULHU;
    end else begin
      mul_sel_s = MUL_OP_MUL;
    end
    if (bus.inst_divu_i) begin
      div_sel_s = DIV_OP_DIVU;
    end else if (bus.inst_rem_i) begin
      div_sel_s = DIV_OP_REM;
    end else if (bus.inst_remu_i) begin
      div_sel_s = DIV_OP_REMU;
    end else begin
      div_sel_s = DIV_OP_DIV;
    end
  end

  // 33-bit sign extension per op, then a 64-bit product; the low 64 bits of
  // the 66-bit signed product are all any RV32M result needs.
  always_comb begin
    mul_a_s = {1'b0, bus.operand_ra_i};
    mul_b_s = {1'b0, bus.operand_rb_i};
    case (mul_sel_s)
      MUL_OP_MULH: begin
        mul_a_s = {bus.operand_ra_i[31], bus.operand_ra_i};
        mul_b_s = {bus.operand_rb_i[31], bus.operand_rb_i};
      end
      MUL_OP_MULHSU: begin
        mul_a_s = {bus.operand_ra_i[31], bus.operand_ra_i};
        mul_b_s = {1'b0, bus.operand_rb_i};
      end
      default: begin
        mul_a_s = {1'b0, bus.operand_ra_i};
        mul_b_s = {1'b0, bus.operand_rb_i};
      end
    endcase
    mul_a_ext_s = {{31{mul_a_s[32]}}, mul_a_s};
    mul_b_ext_s = {{31{mul_b_s[32]}}, mul_b_s};
    mul_prod_s  = mul_a_ext_s * mul_b_ext_s;
    if (mul_sel_s == MUL_OP_MUL) begin
      mul_res_s = mul_prod_s[31:0];
    end else begin
      mul_res_s = mul_prod_s[63:32];
    end
  end

  // Multiplier delay line: each stage carries a result and its valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_valid_r <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        mul_data_r[i] <= 32'd0;
      end
    end else if (bus.flush_i) begin
      mul_valid_r <= '0;
    end else begin
      mul_valid_r[0] <= mul_accept_s;
      mul_data_r[0]  <= mul_res_s;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        mul_valid_r[i] <= mul_valid_r[i-1];
        mul_data_r[i]  <= mul_data_r[i-1];
      end
    end
  end

  uriscv_div_iter #(
    .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE),
    .DIV_EARLY_OUT      (DIV_EARLY_OUT)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (bus.flush_i),
    .start_i    (div_start_s),
    .op_i       (div_sel_s),
    .ra_i       (bus.operand_ra_i),
    .rb_i       (bus.operand_rb_i),
    .busy_o     (div_busy_s),
    .complete_o (div_complete_s),
    .result_o   (div_result_s)
  );

  // Shared result register; a flush suppresses completions still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_r  <= 1'b0;
      result_r <= 32'd0;
    end else if (bus.flush_i) begin
      ready_r <= 1'b0;
    end else if (mul_valid_r[MUL_LATENCY-1]) begin
      ready_r  <= 1'b1;
      result_r <= mul_data_r[MUL_LATENCY-1];
    end else if (div_complete_s) begin
      ready_r  <= 1'b1;
      result_r <= div_result_s;
    end else begin
      ready_r <= 1'b0;
    end
  end

  assign bus.stall_o  = stall_s;
  assign bus.busy_o   = (|mul_valid_r) | div_busy_s;
  assign bus.ready_o  = ready_r;
  assign bus.result_o = result_r;

endmodule

// File: tb/tb_uriscv_muldiv_pipe.sv
// -----------------------------------------------------------------------------
// tb_uriscv_muldiv_pipe
// Directed and randomised checks of the RV32M mul/div unit. Expected results
// come from plain integer arithmetic with the RISC-V divide rules; expected
// ready cycles come from the documented latencies counted from the accept
// cycle.
// -----------------------------------------------------------------------------
module tb_uriscv_muldiv_pipe;

  localparam int MUL_LAT = 2;
  localparam int DIV_K   = 4;
  localparam int EARLY   = 1;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rd = 0;
  ev_t  seen_q[$];
  ev_t  exp_q[$];

  uriscv_muldiv_pipe_if bus();

  uriscv_muldiv_pipe #(
    .MUL_LATENCY        (MUL_LAT),
    .DIV_BITS_PER_CYCLE (DIV_K),
    .DIV_EARLY_OUT      (EARLY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ready pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (bus.ready_o === 1'b1) seen_q.push_back('{cyc, bus.result_o});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 40000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint pr;
    logic [63:0] pu;
    logic [31:0] r;
    sa = a;
    sb = b;
    pr = 64'sd0;
    pu = 64'd0;
    case (op)
      0: begin pu = {32'd0, a} * {32'd0, b}; r = pu[31:0]; end
      1: begin pr = longint'(sa) * longint'(sb); r = pr[63:32]; end
      2: begin pr = longint'(sa) * longint'({32'd0, b}); r = pr[63:32]; end
      3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
      4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input int op, input logic [31:0] b);
    if (op < 4) return MUL_LAT + 1;
    else if (EARLY != 0 && b == 32'd0) return 2;
    else return 32 / DIV_K + 2;
  endfunction

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 7);
    case (s)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b, input bit v);
    bus.valid_i       = v;
    bus.inst_mul_i    = v && (op == 0);
    bus.inst_mulh_i   = v && (op == 1);
    bus.inst_mulhsu_i = v && (op == 2);
    bus.inst_mulhu_i  = v && (op == 3);
    bus.inst_div_i    = v && (op == 4);
    bus.inst_divu_i   = v && (op == 5);
    bus.inst_rem_i    = v && (op == 6);
    bus.inst_remu_i   = v && (op == 7);
    bus.operand_ra_i  = a;
    bus.operand_rb_i  = b;
  endtask

  // Present an op until accepted; optionally record its expected completion.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                       input bit exp_en, input logic [31:0] exp_val,
                       output int acc, output int stalls);
    acc = -1;
    stalls = 0;
    drive(op, a, b, 1'b1);
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (bus.stall_o === 1'b0) begin
        acc = cyc;
        break;
      end
      stalls++;
      step();
    end
    checks++;
    assert (acc >= 0) else begin
      errors++;
      $error("FAIL accept_timeout: op=%0d observed no acceptance, expected acceptance within 64 cycles", op);
    end
    step();
    drive(0, 32'd0, 32'd0, 1'b0);
    if (exp_en && acc >= 0) exp_q.push_back('{acc + lat_of(op, b), exp_val});
  endtask

  // Wait for all expected completions, then compare them and catch extras.
  task automatic drain(input string tag);
    int w;
    w = 0;
    while (((seen_q.size() - rd) < exp_q.size()) && (w < 300)) begin
      step();
      w++;
    end
    repeat (12) step();
    check({tag, "_count"}, 32'(seen_q.size() - rd), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (rd < seen_q.size()) begin
        check({tag, "_cycle"}, 32'(seen_q[rd].cyc), 32'(exp_q[i].cyc));
        check({tag, "_value"}, seen_q[rd].val, exp_q[i].val);
        rd++;
      end
    end
    rd = seen_q.size();
    exp_q.delete();
  endtask

  initial begin
    int a0, a1, s0, s1;
    int accs[4];
    int stl[4];
    int op, gap;
    logic [31:0] ra, rb;

    bus.flush_i = 1'b0;
    drive(0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    rst = 1'b0;
    step();

    // High-half multiplies of all-ones operands.
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, a0, s0);
    issue(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, a0, s0);
    drain("mulh");

    // Back-to-back multiplies never stall each other.
    issue(0, 32'd3, 32'd5, 1'b1, 32'd15, accs[0], stl[0]);
    issue(0, 32'd7, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFF9, accs[1], stl[1]);
    issue(0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, accs[2], stl[2]);
    issue(0, 32'd0, 32'd9, 1'b1, 32'd0, accs[3], stl[3]);
    for (int i = 0; i < 4; i++) begin
      check("b2b_accept", 32'(accs[i] - accs[0]), 32'(i));
      check("b2b_stall", 32'(stl[i]), 32'd0);
    end
    drain("b2b");

    // Signed divide and remainder.
    issue(4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, a0, s0);
    issue(6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, a0, s0);
    drain("divrem");

    // Divide by zero (early out) and signed overflow.
    issue(5, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, a0, s0);
    issue(6, 32'd5, 32'd0, 1'b1, 32'd5, a0, s0);
    issue(4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, a0, s0);
    issue(6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, a0, s0);
    drain("corner");

    // Multiply presented while the divider is busy.
    issue(4, 32'd100, 32'd7, 1'b1, 32'd14, a0, s0);
    issue(0, 32'd6, 32'd7, 1'b1, 32'd42, a1, s1);
    check("mul_wait_accept", 32'(a1 - a0), 32'(32 / DIV_K + 2));
    check("mul_wait_stalls", 32'(s1), 32'(32 / DIV_K + 1));
    drain("haz_div_mul");

    // Divide presented the cycle after a multiply accept.
    issue(0, 32'd2, 32'd3, 1'b1, 32'd6, a0, s0);
    issue(5, 32'd9, 32'd2, 1'b1, 32'd4, a1, s1);
    check("div_wait_accept", 32'(a1 - a0), 32'(MUL_LAT + 1));
    check("div_wait_stalls", 32'(s1), 32'(MUL_LAT));
    drain("haz_mul_div");

    // Flush aborts a divide; a fresh divide then runs normally.
    issue(4, 32'd1234, 32'd5, 1'b0, 32'd0, a0, s0);
    repeat (4) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush_busy", {31'd0, bus.busy_o}, 32'd0);
    issue(5, 32'd9, 32'd3, 1'b1, 32'd3, a1, s1);
    check("flush_new_accept", 32'(a1 - a0), 32'd6);
    drain("flush_div");

    // Flush with a registered ready and an op presented alongside it.
    issue(0, 32'd11, 32'd3, 1'b1, 32'd33, a0, s0);
    issue(0, 32'd4, 32'd4, 1'b0, 32'd0, a1, s1);
    step();
    bus.flush_i = 1'b1;
    drive(0, 32'd7, 32'd7, 1'b1);
    step();
    bus.flush_i = 1'b0;
    drive(0, 32'd0, 32'd0, 1'b0);
    drain("flush_mul");

    // Reset in the middle of a divide.
    issue(4, 32'd1000, 32'd3, 1'b0, 32'd0, a0, s0);
    repeat (2) step();
    rst = 1'b1;
    step();
    check("rstmid_result", bus.result_o, 32'd0);
    check("rstmid_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rstmid_ready", {31'd0, bus.ready_o}, 32'd0);
    rst = 1'b0;
    drain("rst_mid");

    // Random mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      ra = pick();
      rb = pick();
      issue(op, ra, rb, 1'b1, ref_result(op, ra, rb), a0, s0);
      gap = $urandom_range(0, 2);
      repeat (gap) step();
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
